// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, the per-axis phase type and a helper for total period length.
package vga_timing_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FRONT_DEF  = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BACK_DEF   = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FRONT_DEF  = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BACK_DEF   = 33;

   typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} axis_phase_t;

   function automatic int axis_total(input int active_w, input int front_w,
                                     input int sync_w, input int back_w);
      return active_w + front_w + sync_w + back_w;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus the ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE_W = 640,
   parameter int FRONT_W  = 16,
   parameter int SYNC_W   = 96,
   parameter int BACK_W   = 48
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   output logic [9:0]  count,
   output axis_phase_t phase,
   output logic        wrap
);

   localparam int         TOTAL       = axis_total(ACTIVE_W, FRONT_W, SYNC_W, BACK_W);
   localparam logic [9:0] LAST        = 10'(TOTAL - 1);
   localparam logic [9:0] FRONT_START = 10'(ACTIVE_W);
   localparam logic [9:0] SYNC_START  = 10'(ACTIVE_W + FRONT_W);
   localparam logic [9:0] BACK_START  = 10'(ACTIVE_W + FRONT_W + SYNC_W);

   logic [9:0] count_nxt;

   assign count_nxt = (count == LAST) ? 10'd0 : count + 10'd1;
   assign wrap      = advance && (count == LAST);

   // Phase follows the value the counter is about to take, so phase and count stay aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= LAST;
         phase <= BACK;
      end else if (advance) begin
         count <= count_nxt;
         case (phase)
            ACTIVE:  if (count_nxt == FRONT_START) phase <= FRONT;
            FRONT:   if (count_nxt == SYNC_START)  phase <= SYNC;
            SYNC:    if (count_nxt == BACK_START)  phase <= BACK;
            BACK:    if (count_nxt == 10'd0)       phase <= ACTIVE;
            default: phase <= BACK;
         endcase
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel coordinates, blank, delayed syncs,
// line/frame strobes, animation tick and frame counter.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FRONT    = H_FRONT_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BACK     = H_BACK_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FRONT    = V_FRONT_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BACK     = V_BACK_DEF,
   parameter int SYNC_DELAY = 1,
   parameter int ANIM_DIV   = 8
) (
   input  logic        vga_clk,
   input  logic        reset_n,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        blank,
   output logic        hs,
   output logic        vs,
   output logic        line_start,
   output logic        frame_start,
   output logic        anim_tick,
   output logic [15:0] frame_count
);

   localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

   axis_phase_t h_phase;
   axis_phase_t v_phase;
   logic        h_wrap;
   logic        v_wrap;
   logic        hs_raw;
   logic        vs_raw;
   logic [7:0]  anim_cnt;

   vga_axis_counter #(
      .ACTIVE_W (H_ACTIVE),
      .FRONT_W  (H_FRONT),
      .SYNC_W   (H_SYNC),
      .BACK_W   (H_BACK)
   ) u_h_axis (
      .clk     (vga_clk),
      .rst_n   (reset_n),
      .advance (1'b1),
      .count   (DrawX),
      .phase   (h_phase),
      .wrap    (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE_W (V_ACTIVE),
      .FRONT_W  (V_FRONT),
      .SYNC_W   (V_SYNC),
      .BACK_W   (V_BACK)
   ) u_v_axis (
      .clk     (vga_clk),
      .rst_n   (reset_n),
      .advance (h_wrap),
      .count   (DrawY),
      .phase   (v_phase),
      .wrap    (v_wrap)
   );

   assign blank  = (h_phase == ACTIVE) && (v_phase == ACTIVE);
   assign hs_raw = (h_phase != SYNC);
   assign vs_raw = (v_phase != SYNC);

   // v_wrap already implies h_wrap, so it marks the step into (0,0).
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         anim_tick   <= 1'b0;
         anim_cnt    <= ANIM_LAST;
         frame_count <= 16'd0;
      end else begin
         line_start  <= h_wrap;
         frame_start <= v_wrap;
         anim_tick   <= 1'b0;
         if (v_wrap) begin
            frame_count <= frame_count + 16'd1;
            if (anim_cnt == ANIM_LAST) begin
               anim_cnt  <= 8'd0;
               anim_tick <= 1'b1;
            end else begin
               anim_cnt <= anim_cnt + 8'd1;
            end
         end
      end
   end

   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign hs = hs_raw;
         assign vs = vs_raw;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0] hs_pipe;
         logic [SYNC_DELAY-1:0] vs_pipe;

         // Stages reset to the idle-high level so no partial pulse survives a reset.
         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               hs_pipe <= '1;
               vs_pipe <= '1;
            end else begin
               hs_pipe <= SYNC_DELAY'({hs_pipe, hs_raw});
               vs_pipe <= SYNC_DELAY'({vs_pipe, vs_raw});
            end
         end

         assign hs = hs_pipe[SYNC_DELAY-1];
         assign vs = vs_pipe[SYNC_DELAY-1];
      end
   endgenerate

endmodule
